ntt_core_gf64_pmr_reduct: RTL and testbench
===========================================

# ntt_core_gf64_pmr_reduct

Pipelined final modular reduction placed directly downstream of `ntt_core_gf64_pmr_mult`. It takes the multiplier's signed, pseudo-reduced product `z` (MOD_NTT_W+2 bits, two's complement) and returns the canonical residue in [0, MOD_M), where MOD_M = 2^MOD_NTT_W − 2^(MOD_NTT_W/2) + 1 (the Goldilocks prime for the default width). The block forwards the `avail` strobe and the side-band unchanged, with fixed latency, so it can be chained behind the multiplier in the GF64 NTT butterfly datapath.

## Interface
- `MOD_NTT_W`, 64, modulus width; must be even and ≥ 4.
- `OP_W`, MOD_NTT_W+2, input width; fixed to MOD_NTT_W+2.
- `IN_PIPE`, 1, 1 = register the inputs before stage 1.
- `SIDE_W`, 1, side-band width; must be ≥ 1.
- `RST_SIDE`, 2'b00, side-band register policy:
  - bit0 = 1: side registers are reset to 0.
  - bit1 = 1: side registers load only when the avail strobe of that stage is set.
  - bit1 = 0: side registers load every cycle.
- `clk` in 1 clock; all logic is on the rising edge.
- `a_rst_n` in 1 asynchronous active-low reset.
- `in_z` in OP_W signed pseudo-reduced operand (two's complement).
- `in_avail` in 1 `in_z`/`in_side` valid this cycle.
- `in_side` in SIDE_W side-band attached to `in_z`.
- `out_z` out MOD_NTT_W canonical result, always < MOD_M when `out_avail`=1.
- `out_avail` out 1 result valid.
- `out_side` out SIDE_W side-band delayed to match `out_z`.

## Operation
- There is no backpressure. Every `in_avail` pulse produces exactly one `out_avail` pulse after LATENCY cycles. Back-to-back inputs are accepted every cycle.
- Input stage (present only if IN_PIPE=1): registers `in_z`, `in_avail` and `in_side`.
- Stage 1 (fold):
  - Split z = hi·2^W + lo, with hi = z[W+1:W] signed in {−2,−1,0,1} and lo = z[W−1:0] unsigned. W = MOD_NTT_W.
  - Use the identity 2^W ≡ 2^(W/2) − 1 mod MOD_M.
  - Compute t = lo + hi·(2^(W/2) − 1), held as a W+2-bit signed register.
  - Range of t: [−(2^(W/2+1)−2), 2^W + 2^(W/2) − 2].
- Stage 2 (correct):
  - If t < 0, output t + MOD_M.
  - Else if t ≥ MOD_M, output t − MOD_M.
  - Else output t.
  - One correction is always sufficient; no iterative logic.
- The avail pipe is a shift register of LATENCY bits. The side pipe runs in parallel, subject to RST_SIDE.
- Data registers are not reset. Their content is don't-care while the matching avail bit is 0.

## Timing
- LATENCY = 2 + IN_PIPE cycles from `in_avail` to `out_avail`. Default is 3.
- Reset values:
  - All avail bits are 0, so `out_avail`=0.
  - `out_side` is 0 if RST_SIDE[0]=1, otherwise undefined.
  - `out_z` is undefined.
- Assertion of `a_rst_n` takes effect immediately (asynchronous), mid-stream included. In-flight items are dropped and never emerge.
- First accepted input: the first rising edge with `a_rst_n` high and `in_avail`=1.
- Boundary cases:
  - Input exactly MOD_M yields 0.
  - Input −1 yields MOD_M − 1.
  - Both extreme codes (0b01…1 and 0b10…0) reduce correctly, with no overflow of t.

## Configuration
- `NTT_CORE_GF64_PMR_REDUCT_CHECK_EN` defined: simulation-only assertions are compiled in, active while `a_rst_n`=1:
  - `out_avail` ⇒ `out_z` < MOD_M.
  - `in_avail` ⇒ `in_z` is free of X.
  - Any violation reports `$time` and the value via `$error`.
- Undefined: no assertions. Synthesized logic and cycle behaviour are identical in both cases.

## Test plan
For the defaults, MOD_M = 0xFFFFFFFF00000001. Expected values below are for the default configuration (LATENCY=3).
- Special values, one per cycle, in order 0, MOD_M, 66'h3_FFFFFFFFFFFFFFFF (−1), 66'h1_FFFFFFFFFFFFFFFF, 66'h2_0000000000000000:
  - `out_z` = 0, 0, 0xFFFFFFFF00000000, 0x1FFFFFFFD, 0xFFFFFFFD00000003.
  - `out_avail` is high for 5 consecutive cycles starting 3 cycles after the first input.
- Random stream, 10M items:
  - 66-bit `in_z` random, `in_avail` random at ~50% duty, `in_side` = `in_z`[SIDE_W−1:0].
  - Each output equals a reference computed as signed mod MOD_M.
  - `out_side` matches in order.
  - The `out_avail` count equals the `in_avail` count.
- Latency and back-to-back:
  - Single pulse → `out_avail` exactly 3 cycles later, width 1.
  - 100 consecutive pulses → 100 consecutive outputs with no bubbles.
- Reset mid-stream:
  - Drive 4 back-to-back inputs, then pull `a_rst_n` low for 2 cycles right after the 2nd.
  - `out_avail` drops to 0 immediately. No stale outputs appear after release.
  - The next input emerges 3 cycles after acceptance.
- Side policy: run with RST_SIDE = 2'b11.
  - After reset `out_side` = 0.
  - `out_side` changes only on `out_avail` cycles.
  - `out_side` holds its last value during idle gaps.
- Chained with `ntt_core_gf64_pmr_mult`:
  - Random a (66-bit signed) and m (64-bit).
  - Final `out_z` equals (a·m) mod MOD_M for 1M items.

Source files
------------

// File: rtl/ntt_core_gf64_pmr_reduct.sv
// Final reduction of a signed pseudo-reduced GF64 product to a canonical residue in [0, MOD_M).
// Latency 2+IN_PIPE cycles; avail and side-band are delayed alongside the data.
// No backpressure: accepts one item every cycle. NTT_CORE_GF64_PMR_REDUCT_CHECK_EN adds sim checks.
module ntt_core_gf64_pmr_reduct #(
    parameter int          MOD_NTT_W = 64,
    parameter int          OP_W      = MOD_NTT_W + 2,
    parameter int unsigned IN_PIPE   = 1,
    parameter int          SIDE_W    = 1,
    parameter logic [1:0]  RST_SIDE  = 2'b00
) (
    input  logic                 clk,
    input  logic                 a_rst_n,
    input  logic [OP_W-1:0]      in_z,
    input  logic                 in_avail,
    input  logic [SIDE_W-1:0]    in_side,
    output logic [MOD_NTT_W-1:0] out_z,
    output logic                 out_avail,
    output logic [SIDE_W-1:0]    out_side
);

    localparam int LATENCY = 2 + IN_PIPE;
    localparam logic [OP_W-1:0] MOD_M_EXT = (OP_W'(1) << MOD_NTT_W)
                                          - (OP_W'(1) << (MOD_NTT_W / 2)) + OP_W'(1);
    localparam logic [MOD_NTT_W-1:0] MOD_M = MOD_M_EXT[MOD_NTT_W-1:0];

    logic [OP_W-1:0]      s0_z;
    logic [OP_W-1:0]      hi_ext;
    logic [OP_W-1:0]      t_d, t_q;
    logic                 t_neg, t_ge;
    logic [MOD_NTT_W-1:0] res_d, res_q;
    logic [LATENCY-1:0]   avail_d, avail_q;
    logic [SIDE_W-1:0]    side_d [LATENCY];
    logic [SIDE_W-1:0]    side_q [LATENCY];

    generate
        if (IN_PIPE != 0) begin : g_in_pipe
            logic [OP_W-1:0] in_z_d, in_z_q;
            always_comb in_z_d = in_z;
            always_ff @(posedge clk) in_z_q <= in_z_d;
            assign s0_z = in_z_q;
        end else begin : g_no_in_pipe
            assign s0_z = in_z;
        end
    endgenerate

    // Fold: 2^W == 2^(W/2) - 1 (mod M), so hi*2^W becomes hi*2^(W/2) - hi.
    always_comb begin
        hi_ext = {{MOD_NTT_W{s0_z[OP_W-1]}}, s0_z[OP_W-1 -: 2]};
        t_d    = {2'b00, s0_z[MOD_NTT_W-1:0]} + (hi_ext << (MOD_NTT_W / 2)) - hi_ext;
    end

    always_ff @(posedge clk) t_q <= t_d;

    // The corrected value always fits in W bits, so the add/sub runs modulo 2^W.
    always_comb begin
        t_neg = t_q[OP_W-1];
        t_ge  = !t_neg && (t_q >= MOD_M_EXT);
        res_d = t_q[MOD_NTT_W-1:0];
        if (t_neg) begin
            res_d = t_q[MOD_NTT_W-1:0] + MOD_M;
        end else if (t_ge) begin
            res_d = t_q[MOD_NTT_W-1:0] - MOD_M;
        end
    end

    always_ff @(posedge clk) res_q <= res_d;

    always_comb avail_d = {avail_q[LATENCY-2:0], in_avail};

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            avail_q <= '0;
        end else begin
            avail_q <= avail_d;
        end
    end

    // With RST_SIDE[1] a side stage only loads alongside a valid item, otherwise it holds.
    always_comb begin
        side_d[0] = (RST_SIDE[1] && !avail_d[0]) ? side_q[0] : in_side;
        for (int i = 1; i < LATENCY; i++) begin
            side_d[i] = (RST_SIDE[1] && !avail_d[i]) ? side_q[i] : side_q[i-1];
        end
    end

    generate
        if (RST_SIDE[0]) begin : g_side_rst
            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) begin
                    for (int i = 0; i < LATENCY; i++) side_q[i] <= '0;
                end else begin
                    for (int i = 0; i < LATENCY; i++) side_q[i] <= side_d[i];
                end
            end
        end else begin : g_side_norst
            always_ff @(posedge clk) begin
                for (int i = 0; i < LATENCY; i++) side_q[i] <= side_d[i];
            end
        end
    endgenerate

    assign out_z     = res_q;
    assign out_avail = avail_q[LATENCY-1];
    assign out_side  = side_q[LATENCY-1];

`ifdef NTT_CORE_GF64_PMR_REDUCT_CHECK_EN
    always @(posedge clk) begin
        if (a_rst_n && out_avail) begin
            assert (out_z < MOD_M)
                else $error("%0t: out_z %h not below MOD_M", $time, out_z);
        end
        if (a_rst_n && in_avail) begin
            assert (!$isunknown(in_z))
                else $error("%0t: in_z %h carries X/Z while in_avail", $time, in_z);
        end
    end
`else
    // Checks compiled out; the datapath is identical either way.
`endif

endmodule

// File: tb/tb_ntt_core_gf64_pmr_reduct.sv
// Randomized and directed bench for ntt_core_gf64_pmr_reduct against a signed-modulo reference.
// A second instance with RST_SIDE=2'b11 shares the stimulus to exercise the side hold/reset policy.
module tb_ntt_core_gf64_pmr_reduct;

    localparam logic [63:0] M = 64'hFFFF_FFFF_0000_0001;

    logic        clk = 1'b0;
    logic        a_rst_n;
    logic [65:0] in_z;
    logic        in_avail;
    logic [0:0]  in_side;
    logic [7:0]  in_side8;
    logic [63:0] out_z, out_z2;
    logic        out_avail, out_avail2;
    logic [0:0]  out_side;
    logic [7:0]  out_side2;

    always #5 clk = ~clk;

    ntt_core_gf64_pmr_reduct u_dut (
        .clk(clk), .a_rst_n(a_rst_n), .in_z(in_z), .in_avail(in_avail), .in_side(in_side),
        .out_z(out_z), .out_avail(out_avail), .out_side(out_side)
    );

    ntt_core_gf64_pmr_reduct #(.SIDE_W(8), .RST_SIDE(2'b11)) u_dut_side (
        .clk(clk), .a_rst_n(a_rst_n), .in_z(in_z), .in_avail(in_avail), .in_side(in_side8),
        .out_z(out_z2), .out_avail(out_avail2), .out_side(out_side2)
    );

    typedef struct {
        logic [63:0] z;
        logic [7:0]  side;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc_n = 0;
    int          n_out = 0;
    int          n_exp_out = 0;
    logic [7:0]  last_side2;

    function automatic logic [63:0] ref_mod(input logic [65:0] z);
        logic signed [127:0] v, m, r;
        v = {{62{z[65]}}, z};
        m = {64'd0, M};
        r = v % m;
        if (r < 0) r = r + m;
        return r[63:0];
    endfunction

    function automatic logic [65:0] rand66();
        logic [65:0] v;
        v = {2'($urandom_range(3, 0)), $urandom, $urandom};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, expv);
        end
    endtask

    task automatic sample();
        exp_t e;
        logic exp_av;
        if (!a_rst_n) begin
            chk("avail_in_reset", {63'd0, out_avail}, 64'd0);
            chk("avail2_in_reset", {63'd0, out_avail2}, 64'd0);
            return;
        end
        exp_av = (q.size() > 0) && (q[0].due == cyc_n);
        if (out_avail) n_out++;
        chk("out_avail", {63'd0, out_avail}, {63'd0, exp_av});
        chk("out_avail2", {63'd0, out_avail2}, {63'd0, exp_av});
        if (exp_av) begin
            e = q.pop_front();
            if (out_avail) begin
                chk("out_z", out_z, e.z);
                chk("out_side", {63'd0, out_side}, {63'd0, e.side[0]});
                chk("out_z2", out_z2, e.z);
            end
            if (out_avail2) last_side2 = e.side;
        end
        chk("out_side2_hold", {56'd0, out_side2}, {56'd0, last_side2});
    endtask

    // Drive one cycle of input, clock it in, then sample on the following falling edge.
    task automatic cyc(input logic av, input logic [65:0] z, input logic use_exp, input logic [63:0] zexp);
        exp_t e;
        in_avail = av;
        in_z     = z;
        in_side  = z[0:0];
        in_side8 = z[7:0];
        if (av && a_rst_n) begin
            e.z    = use_exp ? zexp : ref_mod(z);
            e.side = z[7:0];
            e.due  = cyc_n + 3;
            q.push_back(e);
            n_exp_out++;
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rand66(), 1'b0, 64'd0);
    endtask

    task automatic rnd(input logic av);
        cyc(av, rand66(), 1'b0, 64'd0);
    endtask

    initial begin
        a_rst_n  = 1'b0;
        in_avail = 1'b0;
        in_z     = '0;
        in_side  = '0;
        in_side8 = '0;
        last_side2 = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_out_avail", {63'd0, out_avail}, 64'd0);
        chk("reset_out_avail2", {63'd0, out_avail2}, 64'd0);
        chk("reset_out_side2", {56'd0, out_side2}, 64'd0);
        a_rst_n = 1'b1;

        // Special values with independently known results.
        cyc(1'b1, 66'h0_0000_0000_0000_0000, 1'b1, 64'h0);
        cyc(1'b1, 66'h0_FFFF_FFFF_0000_0001, 1'b1, 64'h0);
        cyc(1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_0000_0000);
        cyc(1'b1, 66'h1_FFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0000_0001_FFFF_FFFD);
        cyc(1'b1, 66'h2_0000_0000_0000_0000, 1'b1, 64'hFFFF_FFFD_0000_0003);
        idle(5);

        // Single pulse, then a long back-to-back burst.
        rnd(1'b1);
        idle(5);
        for (int i = 0; i < 100; i++) rnd(1'b1);
        idle(4);

        // Random stream at about half duty.
        for (int i = 0; i < 3000; i++) rnd(1'($urandom_range(1, 0)));
        idle(4);

        // Reset mid-stream: two accepted items are dropped, two more offered during reset.
        rnd(1'b1);
        rnd(1'b1);
        a_rst_n = 1'b0;
        #1;
        chk("async_reset_avail", {63'd0, out_avail}, 64'd0);
        chk("async_reset_side2", {56'd0, out_side2}, 64'd0);
        n_exp_out = n_exp_out - q.size();
        q.delete();
        last_side2 = 8'd0;
        @(negedge clk);
        rnd(1'b1);
        rnd(1'b1);
        a_rst_n = 1'b1;
        idle(4);
        rnd(1'b1);
        idle(2);
        rnd(1'b1);
        rnd(1'b1);
        idle(5);

        chk("avail_count", 64'(n_out), 64'(n_exp_out));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
